// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
// Included by the RTL and by the bench so load clamping is defined in one place.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Wide enough for any practical counter width; callers cast down to WIDTH.
    localparam int CLAMP_W = 64;

    function automatic logic [CLAMP_W-1:0] clamp_load(
        input logic [CLAMP_W-1:0] d,
        input logic [CLAMP_W-1:0] max_val
    );
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/counter_step_alu.sv
// Next-count arithmetic for one enabled step: bound-crossing detection, then wrap or saturate.
// Purely combinational, zero latency, no flow control.
module counter_step_alu
    import counter_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               STEP_WIDTH = WIDTH,
    parameter logic [WIDTH-1:0] MAX_VAL    = {WIDTH{1'b1}},
    parameter int               SATURATE   = MODE_WRAP
) (
    input  logic [WIDTH-1:0]      i_q,
    input  logic [STEP_WIDTH-1:0] i_step,
    input  logic                  i_up_down,
    output logic [WIDTH-1:0]      o_next_q,
    output logic                  o_event
);

    // One extra bit so q+step never overflows before the bound compare.
    localparam int CW = ((WIDTH > STEP_WIDTH) ? WIDTH : STEP_WIDTH) + 1;
    localparam logic [CW-1:0] MAX_EXT = CW'(MAX_VAL);
    localparam logic [CW-1:0] MOD     = MAX_EXT + CW'(1);

    logic [CW-1:0] w_q_ext;
    logic [CW-1:0] w_step_ext;
    logic [CW-1:0] w_sum;
    logic [CW-1:0] w_diff;

    always_comb begin
        w_q_ext    = CW'(i_q);
        w_step_ext = CW'(i_step);
        w_sum      = w_q_ext + w_step_ext;
        w_diff     = w_q_ext - w_step_ext;
        o_next_q   = i_q;
        o_event    = 1'b0;
        if (i_up_down) begin
            if (w_sum <= MAX_EXT) begin
                o_next_q = WIDTH'(w_sum);
            end else begin
                o_event  = 1'b1;
                o_next_q = (SATURATE == MODE_SAT) ? MAX_VAL : WIDTH'(w_sum - MOD);
            end
        end else begin
            if (w_step_ext <= w_q_ext) begin
                o_next_q = WIDTH'(w_diff);
            end else begin
                o_event  = 1'b1;
                o_next_q = (SATURATE == MODE_SAT) ? '0 : WIDTH'(w_q_ext + MOD - w_step_ext);
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Configurable up/down counter with clear/load/enable priority, wrap pulse, sticky overflow and compare.
// q/wrap/ovf update one edge after inputs; zero/match follow q combinationally; never stalls.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] MAX_VAL    = {WIDTH{1'b1}},
    parameter int               STEP_WIDTH = WIDTH,
    parameter int               SATURATE   = MODE_WRAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      d,
    input  logic                  en,
    input  logic                  up_down,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      cmp,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      q,
    output logic                  zero,
    output logic                  match,
    output logic                  wrap,
    output logic                  ovf
);

    localparam int CW = ((WIDTH > STEP_WIDTH) ? WIDTH : STEP_WIDTH) + 1;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next_q;
    logic             w_event;
    logic [WIDTH-1:0] w_load_val;
    logic             w_count;

    counter_step_alu #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH),
        .MAX_VAL    (MAX_VAL),
        .SATURATE   (SATURATE)
    ) u_alu (
        .i_q       (r_q),
        .i_step    (step),
        .i_up_down (up_down),
        .o_next_q  (w_next_q),
        .o_event   (w_event)
    );

    assign w_load_val = WIDTH'(clamp_load(CLAMP_W'(d), CLAMP_W'(MAX_VAL)));
    assign w_count    = en && !clear && !load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (clear) begin
                r_q <= '0;
            end else if (load) begin
                r_q <= w_load_val;
            end else if (en) begin
                r_q    <= w_next_q;
                r_wrap <= w_event;
            end
            // A new event outranks a simultaneous clear request.
            if (w_count && w_event) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign q     = r_q;
    assign wrap  = r_wrap;
    assign ovf   = r_ovf;
    assign zero  = (r_q == '0);
    assign match = (r_q == cmp);

    a_step_range: assert property (@(posedge clk) disable iff (rst)
        en |-> (CW'(step) <= CW'(MAX_VAL)));

endmodule

// File: tb/tb_param_updown_counter.sv
// Drives three counter variants (full-range wrap, decade wrap, decade saturate) from one stimulus
// stream and compares every output each cycle against an arithmetic reference model.
module tb_param_updown_counter;
    import counter_pkg::*;

    logic       clk;
    logic       rst, clear, load, en, up_down, ovf_clr;
    logic [7:0] d, step, cmp;

    logic [7:0] q_o     [3];
    logic       zero_o  [3];
    logic       match_o [3];
    logic       wrap_o  [3];
    logic       ovf_o   [3];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state: limit and mode per instance, count and flags as plain integers.
    int m_max [3] = '{255, 9, 9};
    bit m_sat [3] = '{1'b0, 1'b0, 1'b1};
    int m_q   [3];
    bit m_w   [3];
    bit m_o   [3];

    param_updown_counter u_dut_full (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .d(d), .en(en),
        .up_down(up_down), .step(step), .cmp(cmp), .ovf_clr(ovf_clr),
        .q(q_o[0]), .zero(zero_o[0]), .match(match_o[0]), .wrap(wrap_o[0]), .ovf(ovf_o[0])
    );

    param_updown_counter #(.MAX_VAL(8'd9), .SATURATE(MODE_WRAP)) u_dut_dec (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .d(d), .en(en),
        .up_down(up_down), .step(step), .cmp(cmp), .ovf_clr(ovf_clr),
        .q(q_o[1]), .zero(zero_o[1]), .match(match_o[1]), .wrap(wrap_o[1]), .ovf(ovf_o[1])
    );

    param_updown_counter #(.MAX_VAL(8'd9), .SATURATE(MODE_SAT)) u_dut_sat (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .d(d), .en(en),
        .up_down(up_down), .step(step), .cmp(cmp), .ovf_clr(ovf_clr),
        .q(q_o[2]), .zero(zero_o[2]), .match(match_o[2]), .wrap(wrap_o[2]), .ovf(ovf_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge();
        for (int k = 0; k < 3; k++) begin
            int lim;
            int total;
            bit ev;
            lim = m_max[k] + 1;
            ev  = 1'b0;
            if (rst) begin
                m_q[k] = 0;
                m_w[k] = 1'b0;
                m_o[k] = 1'b0;
            end else begin
                if (clear) begin
                    m_q[k] = 0;
                end else if (load) begin
                    m_q[k] = int'(clamp_load(CLAMP_W'(d), CLAMP_W'(m_max[k])));
                end else if (en) begin
                    total = up_down ? m_q[k] + int'(step) : m_q[k] - int'(step);
                    ev = (total < 0) || (total >= lim);
                    if (ev && m_sat[k])
                        m_q[k] = up_down ? m_max[k] : 0;
                    else
                        m_q[k] = (total + lim) % lim;
                end
                m_w[k] = ev;
                if (ev)           m_o[k] = 1'b1;
                else if (ovf_clr) m_o[k] = 1'b0;
            end
        end
    endfunction

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("q[%0d]", k),     32'(q_o[k]),     32'(m_q[k]));
            chk($sformatf("zero[%0d]", k),  32'(zero_o[k]),  32'(m_q[k] == 0));
            chk($sformatf("match[%0d]", k), 32'(match_o[k]), 32'(m_q[k] == int'(cmp)));
            chk($sformatf("wrap[%0d]", k),  32'(wrap_o[k]),  32'(m_w[k]));
            chk($sformatf("ovf[%0d]", k),   32'(ovf_o[k]),   32'(m_o[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit i_rst, input bit i_clr, input bit i_ld, input logic [7:0] i_d,
                         input bit i_en, input bit i_up, input logic [7:0] i_step,
                         input logic [7:0] i_cmp, input bit i_oc);
        rst = i_rst; clear = i_clr; load = i_ld; d = i_d; en = i_en;
        up_down = i_up; step = i_step; cmp = i_cmp; ovf_clr = i_oc;
        tick();
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; load = 1'b0; en = 1'b0; up_down = 1'b1; ovf_clr = 1'b0;
        d = '0; step = '0; cmp = '0;

        // Reset state, then count up five times.
        drive(1, 0, 0, 8'h00, 0, 1, 8'd0, 8'd0, 0);
        chk("rst_q", 32'(q_o[0]), 0);
        chk("rst_zero", 32'(zero_o[0]), 1);
        chk("rst_match", 32'(match_o[0]), 1);
        repeat (5) drive(0, 0, 0, 8'h00, 1, 1, 8'd1, 8'd0, 0);
        chk("cnt5_q", 32'(q_o[0]), 5);
        chk("cnt5_zero", 32'(zero_o[0]), 0);
        chk("cnt5_ovf", 32'(ovf_o[0]), 0);

        // Decade wrap up then down.
        drive(0, 0, 1, 8'd8, 0, 1, 8'd0, 8'd0, 0);
        drive(0, 0, 0, 8'd0, 1, 1, 8'd3, 8'd0, 0);
        chk("dec_up_q", 32'(q_o[1]), 1);
        chk("dec_up_wrap", 32'(wrap_o[1]), 1);
        chk("dec_up_ovf", 32'(ovf_o[1]), 1);
        drive(0, 0, 0, 8'd0, 1, 0, 8'd2, 8'd0, 0);
        chk("dec_dn_q", 32'(q_o[1]), 9);
        chk("dec_dn_wrap", 32'(wrap_o[1]), 1);
        drive(0, 0, 0, 8'd0, 0, 0, 8'd2, 8'd0, 0);
        chk("dec_idle_wrap", 32'(wrap_o[1]), 0);

        // Saturation at the top, held, then legal full-range step down.
        drive(0, 0, 1, 8'd7, 0, 1, 8'd0, 8'd0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 8'd0, 1, 1, 8'd5, 8'd0, 0);
            chk("sat_q", 32'(q_o[2]), 9);
            chk("sat_wrap", 32'(wrap_o[2]), 1);
        end
        drive(0, 0, 0, 8'd0, 1, 0, 8'd9, 8'd0, 0);
        chk("sat_dn_q", 32'(q_o[2]), 0);
        chk("sat_dn_wrap", 32'(wrap_o[2]), 0);

        // Priority: clear beats load beats enable; load clamps.
        drive(0, 1, 1, 8'h55, 1, 1, 8'd1, 8'd0, 0);
        chk("prio_clr_q", 32'(q_o[0]), 0);
        drive(0, 0, 1, 8'h55, 1, 1, 8'd1, 8'd0, 0);
        chk("prio_ld_q", 32'(q_o[0]), 32'h55);
        chk("prio_ld_wrap", 32'(wrap_o[0]), 0);
        chk("prio_ld_clamp", 32'(q_o[1]), 9);
        drive(0, 0, 1, 8'd12, 0, 1, 8'd1, 8'd0, 0);
        chk("ld12_q", 32'(q_o[1]), 9);

        // Sticky overflow: set wins over ovf_clr, ovf_clr alone clears, clear keeps it.
        drive(0, 0, 0, 8'd0, 0, 1, 8'd0, 8'd0, 1);
        drive(0, 0, 1, 8'd254, 0, 1, 8'd0, 8'd0, 0);
        drive(0, 0, 0, 8'd0, 1, 1, 8'd3, 8'd0, 1);
        chk("stk_q", 32'(q_o[0]), 1);
        chk("stk_set_wins", 32'(ovf_o[0]), 1);
        drive(0, 0, 0, 8'd0, 0, 1, 8'd0, 8'd0, 1);
        chk("stk_clr", 32'(ovf_o[0]), 0);
        drive(0, 0, 1, 8'd254, 0, 1, 8'd0, 8'd0, 0);
        drive(0, 0, 0, 8'd0, 1, 1, 8'd3, 8'd0, 0);
        drive(0, 1, 0, 8'd0, 0, 1, 8'd0, 8'd0, 0);
        chk("stk_keep_q", 32'(q_o[0]), 0);
        chk("stk_keep_ovf", 32'(ovf_o[0]), 1);

        // Compare, zero, and reset mid-count.
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 8'd0, 1, 1, 8'd1, 8'd3, 0);
            chk("cmp_match", 32'(match_o[0]), 32'(i == 3));
        end
        drive(0, 0, 1, 8'd1, 0, 1, 8'd0, 8'd3, 0);
        drive(0, 0, 0, 8'd0, 1, 0, 8'd1, 8'd3, 0);
        chk("dn_zero", 32'(zero_o[0]), 1);
        drive(0, 0, 1, 8'h40, 0, 1, 8'd0, 8'd3, 0);
        drive(1, 1, 1, 8'h40, 1, 1, 8'd1, 8'd3, 1);
        chk("rst_mid_q", 32'(q_o[0]), 0);
        chk("rst_mid_ovf", 32'(ovf_o[0]), 0);

        // Randomised traffic; step kept within the smallest modulus.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0,
                  8'($urandom),
                  $urandom_range(0, 3) != 0,
                  1'($urandom),
                  8'($urandom_range(0, 9)),
                  8'($urandom_range(0, 12)),
                  $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the 8-bit behavioural up/down counter. Width, modulus, step size and overflow mode (wrap or saturate) are configurable. Adds a count enable, registered wrap/saturate event pulses, a sticky overflow flag and a compare-match output. Used as a general-purpose event, timer and address counter in datapath and testbench infrastructure.

Parameters:
WIDTH, 8, counter width in bits (>=2).
MAX_VAL, 2**WIDTH-1, terminal count; range is 0..MAX_VAL inclusive (MAX_VAL <= 2**WIDTH-1).
STEP_WIDTH, WIDTH, width of step input.
SATURATE, 0, 0 = modulo wrap, 1 = saturate at 0 / MAX_VAL.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
clear  in  1  synchronous count clear; q to 0, flags kept
load  in  1  parallel load of d
d  in  WIDTH  load value
en  in  1  count enable
up_down  in  1  1 = count up, 0 = count down
step  in  STEP_WIDTH  increment/decrement amount per enabled cycle
cmp  in  WIDTH  compare value
ovf_clr  in  1  clears sticky ovf
q  out  WIDTH  current count
zero  out  1  q == 0 (combinational from q register)
match  out  1  q == cmp (combinational)
wrap  out  1  one-cycle pulse: previous update crossed a bound
ovf  out  1  sticky: any wrap/saturate event since last clear

Behaviour:
- Reset: q=0, wrap=0, ovf=0; zero=1; match=(cmp==0).
- Priority per cycle: rst > clear > load > en. None active: q holds, wrap=0.
- clear: q<=0, wrap<=0; ovf unchanged.
- load: q<=d; if d>MAX_VAL then q<=MAX_VAL. No wrap pulse. en ignored.
- en, up: sum = q+step computed in WIDTH+1 bits. If sum<=MAX_VAL, q<=sum. Else event: wrap mode q<=sum-(MAX_VAL+1); saturate mode q<=MAX_VAL.
- en, down: if step<=q, q<=q-step. Else event: wrap mode q<=q+(MAX_VAL+1)-step; saturate mode q<=0.
- step > MAX_VAL is unsupported. An assertion flags it in simulation.
- step=0 with en: q holds, no event.
- Saturate mode at a bound: the event fires every enabled cycle that would exceed the bound. wrap pulses each such cycle.
- Latency: q, wrap and ovf update on the clock edge after the qualifying input. zero and match follow q combinationally, with 0 cycles after q.
- wrap: registered; 1 for exactly the cycle following an event cycle.
- ovf: set on event. Cleared by rst or ovf_clr. Event and ovf_clr in the same cycle: ovf stays 1 (set wins).
- rst mid-count: everything returns to reset values on the next edge regardless of other inputs.

Decomposition:
- Package counter_pkg holds:
  - the constants MODE_WRAP=0 and MODE_SAT=1;
  - a function clamp_load(d, max) used by RTL and bench.
- Sub-module counter_step_alu (combinational) takes q, step, up_down, MAX_VAL and SATURATE. It outputs next_q and event. The top holds the registers, priority logic and flags.

Test Plan:
1. Reset then count: WIDTH=8, defaults; rst 1 cycle, en=1, up, step=1 for 5 cycles -> q=5, zero=0, wrap=0, ovf=0.
2. Decade wrap: MAX_VAL=9, SATURATE=0, load d=8, then up step=3 -> q=1, wrap=1 for one cycle, ovf=1. Then down step=2 -> q=9, wrap pulses again.
3. Saturate: MAX_VAL=9, SATURATE=1, load 7, up step=5 -> q=9, wrap=1. Hold en 2 more cycles -> q=9, wrap=1 each cycle. Down step=20 is illegal and must trigger the assertion; down step=9 from 9 -> q=0.
4. Priority: in one cycle assert clear, load with d=0x55, and en -> q=0. Next cycle, load with d=0x55 and en=1 -> q=0x55, no wrap. Load d=12 with MAX_VAL=9 -> q=9.
5. Sticky flag: force a wrap while ovf_clr=1 in the same cycle -> ovf=1. ovf_clr alone next cycle -> ovf=0. clear does not clear ovf.
6. Compare/zero: cmp=3, count up from 0 -> match high only while q=3. Down from 1 step 1 -> zero=1 with q=0. rst mid-count (q=0x40) -> q=0, ovf=0 next edge.
